// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared bus width and loader FSM encoding
package program_loader_pkg;

    // Width of the shared main bus.
    localparam int BUS_W = 8;

    // Loader sequencer states; the encoding is also decoded by control_logic.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD      = 3'd1,
        ST_WAIT_BYTE = 3'd2,
        ST_A_SETUP   = 3'd3,
        ST_A_CLK     = 3'd4,
        ST_D_SETUP   = 3'd5,
        ST_D_CLK     = 3'd6,
        ST_RELEASE   = 3'd7
    } state_t;

    // True in the four states that actively drive the bus.
    function automatic logic is_drive_state(input state_t s);
        return (s == ST_A_SETUP) || (s == ST_A_CLK) ||
               (s == ST_D_SETUP) || (s == ST_D_CLK);
    endfunction

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - freezes the CPU and writes a byte stream into RAM over the main bus
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int SETUP  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [BUS_W-1:0]  byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              hold_req,
    input  logic              hold_ack,
    output logic [BUS_W-1:0]  bus_out,
    output logic              bus_oe,
    output logic              mi,
    output logic              ri,
    output logic              load_clk,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    // Setup counter only needs to reach SETUP-1.
    localparam int SC_W = (SETUP > 1) ? $clog2(SETUP) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETUP - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [SC_W-1:0]   setup_cnt_q, setup_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [BUS_W-1:0]  byte_q, byte_d;
    logic              last_q, last_d;
    logic              abort_q, abort_d;

    // Abort seen now or earlier in this load; it takes effect at the next byte boundary.
    logic abort_any;
    assign abort_any = abort | abort_q;

    // State and datapath registers; async reset returns everything to IDLE at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            setup_cnt_q <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            byte_q      <= '0;
            last_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            abort_q     <= abort_d;
        end
    end

    // Next-state logic: handshake, setup timing, address/count advance and termination.
    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        addr_d      = addr_q;
        count_d     = count_q;
        byte_d      = byte_q;
        last_d      = last_q;
        abort_d     = abort_q;

        // Remember an abort raised mid-byte so the write in flight still finishes.
        if (abort && (state_q != ST_IDLE) && (state_q != ST_RELEASE)) begin
            abort_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    state_d = ST_HOLD;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            ST_HOLD: begin
                if (hold_ack) begin
                    state_d = ST_WAIT_BYTE;
                end
            end
            ST_WAIT_BYTE: begin
                if (byte_valid) begin
                    byte_d      = byte_in;
                    last_d      = byte_last;
                    setup_cnt_d = '0;
                    state_d     = ST_A_SETUP;
                end else if (abort_any) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_A_SETUP: begin
                if (setup_cnt_q == SC_LAST) begin
                    setup_cnt_d = '0;
                    state_d     = ST_A_CLK;
                end else begin
                    setup_cnt_d = setup_cnt_q + 1'b1;
                end
            end
            ST_A_CLK: begin
                setup_cnt_d = '0;
                state_d     = ST_D_SETUP;
            end
            ST_D_SETUP: begin
                if (setup_cnt_q == SC_LAST) begin
                    setup_cnt_d = '0;
                    state_d     = ST_D_CLK;
                end else begin
                    setup_cnt_d = setup_cnt_q + 1'b1;
                end
            end
            ST_D_CLK: begin
                addr_d  = addr_q + 1'b1;
                count_d = count_q + 1'b1;
                if (last_q || abort_any || (addr_q == ADDR_MAX)) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_WAIT_BYTE;
                end
            end
            ST_RELEASE: begin
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so an async reset drops them immediately.
    always_comb begin
        byte_ready = 1'b0;
        hold_req   = 1'b0;
        bus_out    = '0;
        bus_oe     = 1'b0;
        mi         = 1'b0;
        ri         = 1'b0;
        load_clk   = 1'b0;
        busy       = (state_q != ST_IDLE);
        done       = 1'b0;
        count      = count_q;

        hold_req = (state_q != ST_IDLE) && (state_q != ST_RELEASE);
        bus_oe   = is_drive_state(state_q);

        case (state_q)
            ST_WAIT_BYTE: begin
                byte_ready = 1'b1;
            end
            ST_A_SETUP, ST_A_CLK: begin
                bus_out  = BUS_W'(addr_q);
                mi       = 1'b1;
                load_clk = (state_q == ST_A_CLK);
            end
            ST_D_SETUP, ST_D_CLK: begin
                bus_out  = byte_q;
                ri       = 1'b1;
                load_clk = (state_q == ST_D_CLK);
            end
            ST_RELEASE: begin
                done = 1'b1;
            end
            default: begin
                byte_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;

    localparam int ADDR_W = 4;
    localparam int SETUP  = 2;
    localparam int NWORDS = 1 << ADDR_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [7:0]      byte_in = '0;
    logic            byte_valid = 1'b0;
    logic            byte_last = 1'b0;
    logic            hold_ack = 1'b0;
    logic            byte_ready, hold_req, bus_oe, mi, ri, load_clk, busy, done;
    logic [7:0]      bus_out;
    logic [ADDR_W:0] count;

    int checks = 0;
    int passes = 0;

    program_loader #(.ADDR_W(ADDR_W), .SETUP(SETUP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(byte_ready), .hold_req(hold_req), .hold_ack(hold_ack),
        .bus_out(bus_out), .bus_oe(bus_oe), .mi(mi), .ri(ri),
        .load_clk(load_clk), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    // Bus-side observer: a MAR/RAM model plus protocol rule violations.
    int         wr_addr[$];
    int         wr_data[$];
    int         acc_cyc[$];
    int         viol = 0;
    int         done_cnt = 0;
    int         cyc_n = 0;
    int         last_dclk_cyc = -10;
    int         done_cyc = -20;
    int         run_len = 0;
    logic [7:0] mar_m = '0;
    logic [7:0] prev_bus = '0;
    logic       prev_mi = 1'b0;
    logic       prev_ri = 1'b0;

    always @(negedge clk) begin
        cyc_n++;
        if (!rst_n) begin
            run_len = 0;
            prev_mi = 1'b0;
            prev_ri = 1'b0;
        end else begin
            if (mi && ri) viol++;
            if (bus_oe !== (mi | ri)) viol++;
            if (mi && (bus_out >> ADDR_W) != 0) viol++;
            if (done && (hold_req || bus_oe)) viol++;
            if ((mi && prev_mi) || (ri && prev_ri)) begin
                if (bus_out !== prev_bus) viol++;
                run_len++;
            end else if (mi || ri) begin
                run_len = 1;
            end else begin
                run_len = 0;
            end
            if (load_clk) begin
                if (!(mi || ri)) viol++;
                if (run_len != SETUP + 1) viol++;
                if (mi) mar_m = bus_out;
                if (ri) begin
                    wr_addr.push_back(int'(mar_m) % NWORDS);
                    wr_data.push_back(int'(bus_out));
                    last_dclk_cyc = cyc_n;
                end
            end
            if (byte_ready && byte_valid) acc_cyc.push_back(cyc_n);
            if (done) begin
                done_cnt++;
                done_cyc = cyc_n;
            end
            prev_mi  = mi;
            prev_ri  = ri;
            prev_bus = bus_out;
        end
    end

    // Byte source: bytes to offer and bytes the loader actually took.
    logic [7:0] tx_data[$];
    bit         tx_last[$];
    logic [7:0] acc_q[$];

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        acc_cyc.delete();
        acc_q.delete();
        tx_data.delete();
        tx_last.delete();
        viol = 0;
        done_cnt = 0;
    endtask

    task automatic feed(input int budget, input bit gaps);
        int cyc = 0;
        while (tx_data.size() > 0 && cyc < budget) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_in    = tx_data[0];
                byte_last  = tx_last[0];
            end
            @(negedge clk);
            if (byte_valid && byte_ready) begin
                acc_q.push_back(tx_data[0]);
                void'(tx_data.pop_front());
                void'(tx_last.pop_front());
            end
            @(posedge clk); #1;
            cyc++;
            if (!busy) break;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic start_load(input int ack_delay);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (ack_delay) begin
            @(posedge clk); #1;
        end
        hold_ack = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        hold_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({byte_ready, hold_req, bus_out, bus_oe, mi, ri, load_clk, busy, done, count} !== '0)
            $display("FAIL reset_outputs: got %b required all zero",
                     {byte_ready, hold_req, bus_out, bus_oe, mi, ri, load_clk, busy, done, count});
        else passes++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b required 0", busy);
        else passes++;
    endtask

    task automatic test_full_load();
        bit ok;
        clear_mon();
        for (int i = 0; i < NWORDS; i++) begin
            tx_data.push_back(8'(8'h10 + i));
            tx_last.push_back(1'b0);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (hold_req !== 1'b1 || busy !== 1'b1)
            $display("FAIL full_start_hold: hold_req=%b busy=%b required 1 1", hold_req, busy);
        else passes++;
        repeat (3) begin
            @(posedge clk); #1;
        end
        hold_ack = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (byte_ready !== 1'b1) $display("FAIL full_ack_ready: byte_ready=%b required 1", byte_ready);
        else passes++;
        feed(1000, 1'b1);
        wait_idle(100, ok);
        checks++;
        if (!ok) $display("FAIL full_timeout: busy=%b required 0", busy);
        else passes++;
        checks++;
        if (wr_addr.size() != NWORDS) $display("FAIL full_nwrites: got %0d required %0d", wr_addr.size(), NWORDS);
        else passes++;
        for (int i = 0; i < wr_addr.size() && i < NWORDS; i++) begin
            checks++;
            if (wr_addr[i] != i || wr_data[i] != 8'h10 + i)
                $display("FAIL full_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                         i, wr_addr[i], wr_data[i], i, 8'h10 + i);
            else passes++;
        end
        checks++;
        if (count !== 5'(NWORDS) || done_cnt != 1 || hold_req !== 1'b0)
            $display("FAIL full_end: count=%0d done_pulses=%0d hold_req=%b required %0d 1 0",
                     count, done_cnt, hold_req, NWORDS);
        else passes++;
        checks++;
        if (viol != 0) $display("FAIL full_protocol: violations=%0d required 0", viol);
        else passes++;
    endtask

    task automatic test_early_last();
        bit ok;
        int n;
        for (int k = 0; k < 4; k++) begin
            clear_mon();
            n = (k == 0) ? 3 : int'($urandom_range(1, NWORDS - 1));
            for (int i = 0; i < n; i++) begin
                if (k == 0) tx_data.push_back(8'(8'hAA + 8'h11 * i));
                else        tx_data.push_back(8'($urandom));
                tx_last.push_back(i == n - 1);
            end
            start_load($urandom_range(0, 5));
            feed(1000, 1'b1);
            wait_idle(100, ok);
            checks++;
            if (!ok || count !== 5'(n) || done_cnt != 1)
                $display("FAIL early_end%0d: idle=%b count=%0d done_pulses=%0d required 1 %0d 1",
                         k, ok, count, done_cnt, n);
            else passes++;
            checks++;
            if (done_cyc != last_dclk_cyc + 1)
                $display("FAIL early_done_lat%0d: done at %0d last load_clk at %0d required +1",
                         k, done_cyc, last_dclk_cyc);
            else passes++;
            for (int i = 0; i < n; i++) begin
                checks++;
                if (i >= wr_addr.size() || i >= acc_q.size() || wr_addr[i] != i || wr_data[i] != int'(acc_q[i]))
                    $display("FAIL early_write%0d_%0d: writes=%0d required addr=%0d data=%h",
                             k, i, wr_addr.size(), i, (i < acc_q.size()) ? acc_q[i] : 8'h00);
                else passes++;
            end
            checks++;
            if (wr_addr.size() != n || viol != 0)
                $display("FAIL early_extra%0d: writes=%0d viol=%0d required %0d 0", k, wr_addr.size(), viol, n);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit gaps_ok;
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            tx_data.push_back(8'($urandom));
            tx_last.push_back(i == 5);
        end
        start_load(1);
        feed(1000, 1'b0);
        wait_idle(100, ok);
        gaps_ok = (acc_cyc.size() == 6);
        for (int i = 1; i < acc_cyc.size(); i++)
            if (acc_cyc[i] - acc_cyc[i-1] != 2 * (SETUP + 1) + 1) gaps_ok = 1'b0;
        checks++;
        if (!gaps_ok)
            $display("FAIL b2b_period: accepts=%0d first gap=%0d required 6 accepts every %0d cycles",
                     acc_cyc.size(), (acc_cyc.size() > 1) ? acc_cyc[1] - acc_cyc[0] : -1, 2 * (SETUP + 1) + 1);
        else passes++;
        checks++;
        if (!ok || count !== 5'd6 || wr_addr.size() != 6 || viol != 0)
            $display("FAIL b2b_end: idle=%b count=%0d writes=%0d viol=%0d required 1 6 6 0",
                     ok, count, wr_addr.size(), viol);
        else passes++;
    endtask

    task automatic test_abort();
        bit ok;
        bit idle_ok;
        // Abort mid-byte: the fifth byte still lands.
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            tx_data.push_back(8'($urandom));
            tx_last.push_back(1'b0);
        end
        start_load(2);
        fork
            feed(1000, 1'b1);
            begin
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    if (acc_q.size() == 5 && ri && !load_clk) break;
                end
                abort = 1'b1;
                for (int i = 0; i < 100 && busy; i++) @(posedge clk);
                #1 abort = 1'b0;
            end
        join
        wait_idle(100, ok);
        checks++;
        if (!ok || count !== 5'd5 || wr_addr.size() != 5 || done_cnt != 1)
            $display("FAIL abort_mid: idle=%b count=%0d writes=%0d done_pulses=%0d required 1 5 5 1",
                     ok, count, wr_addr.size(), done_cnt);
        else passes++;
        checks++;
        if (wr_addr.size() == 5 && (wr_addr[4] != 4 || wr_data[4] != int'(acc_q[4])))
            $display("FAIL abort_mid_last: addr=%0d data=%h required 4 %h", wr_addr[4], wr_data[4], acc_q[4]);
        else passes++;

        // Abort while waiting for the third byte.
        clear_mon();
        for (int i = 0; i < 2; i++) begin
            tx_data.push_back(8'($urandom));
            tx_last.push_back(1'b0);
        end
        start_load(0);
        feed(1000, 1'b1);
        for (int i = 0; i < 50 && !(byte_ready && count == 5'd2); i++) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle(100, ok);
        checks++;
        if (!ok || count !== 5'd2 || wr_addr.size() != 2 || done_cnt != 1 || viol != 0)
            $display("FAIL abort_wait: idle=%b count=%0d writes=%0d done_pulses=%0d viol=%0d required 1 2 2 1 0",
                     ok, count, wr_addr.size(), done_cnt, viol);
        else passes++;

        // Abort is ignored in IDLE.
        idle_ok = 1'b1;
        abort = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy || done || hold_req) idle_ok = 1'b0;
        end
        abort = 1'b0;
        checks++;
        if (!idle_ok) $display("FAIL abort_idle: busy=%b done=%b required 0 0", busy, done);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found;
        clear_mon();
        start_load(1);
        byte_valid = 1'b1;
        byte_in    = 8'($urandom);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (load_clk && mi) begin
                found = 1'b1;
                break;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (!found || bus_oe !== 1'b0 || hold_req !== 1'b0 || load_clk !== 1'b0 || mi !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_mid: found=%b bus_oe=%b hold_req=%b load_clk=%b mi=%b required 1 0 0 0 0",
                     found, bus_oe, hold_req, load_clk, mi);
        else passes++;
        byte_valid = 1'b0;
        hold_ack   = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            tx_data.push_back(8'($urandom));
            tx_last.push_back(i == 2);
        end
        start_load(1);
        feed(1000, 1'b1);
        wait_idle(100, ok);
        checks++;
        if (!ok || wr_addr.size() != 3 || wr_addr[0] != 0 || wr_data[0] != int'(acc_q[0]) || count !== 5'd3)
            $display("FAIL reset_restart: idle=%b writes=%0d first_addr=%0d count=%0d required 1 3 0 3",
                     ok, wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : -1, count);
        else passes++;
    endtask

    task automatic test_start_busy();
        bit ok;
        bit seq_ok;
        bit stall_ok;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            tx_data.push_back(8'($urandom));
            tx_last.push_back(i == 3);
        end
        start_load(2);
        fork
            feed(1000, 1'b1);
            begin
                for (int i = 0; i < 300 && busy; i++) begin
                    if (!done && $urandom_range(0, 1) == 1) start = 1'b1;
                    hold_ack = 1'b0;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
                start = 1'b0;
            end
        join
        wait_idle(100, ok);
        seq_ok = (wr_addr.size() == 4);
        for (int i = 0; i < wr_addr.size(); i++)
            if (i >= acc_q.size() || wr_addr[i] != i || wr_data[i] != int'(acc_q[i])) seq_ok = 1'b0;
        checks++;
        if (!ok || !seq_ok || count !== 5'd4 || done_cnt != 1 || viol != 0)
            $display("FAIL start_busy: idle=%b seq_ok=%b count=%0d done_pulses=%0d viol=%0d required 1 1 4 1 0",
                     ok, seq_ok, count, done_cnt, viol);
        else passes++;

        // Withheld acknowledge keeps the loader parked in HOLD.
        clear_mon();
        hold_ack = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stall_ok = 1'b1;
        repeat (100) begin
            if (hold_req !== 1'b1 || bus_oe !== 1'b0 || byte_ready !== 1'b0) stall_ok = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (!stall_ok) $display("FAIL hold_stall: hold_req=%b bus_oe=%b byte_ready=%b required 1 0 0",
                                hold_req, bus_oe, byte_ready);
        else passes++;
        hold_ack = 1'b1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle(100, ok);
        checks++;
        if (!ok || count !== 5'd0 || wr_addr.size() != 0 || done_cnt != 1)
            $display("FAIL hold_stall_end: idle=%b count=%0d writes=%0d done_pulses=%0d required 1 0 0 1",
                     ok, count, wr_addr.size(), done_cnt);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_early_last();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_start_busy();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Sequencer that loads a program into the 16-byte RAM over the shared 8-bit main bus while the CPU is frozen. It sits beside the control logic: it requests a CPU hold, takes ownership of the bus, and performs MI/RI write cycles from an incoming byte stream (UART receiver or DIP-switch entry). It then releases the bus and CPU. During a load, the top level muxes its `load_clk` pulse onto the RAM/MAR clock and ORs its `mi`/`ri` strobes with the control-logic strobes.

## Interface
- `ADDR_W`, default 4: RAM address width; number of bytes loaded = 2^ADDR_W.
- `SETUP`, default 2: clk cycles the bus value and strobe are held stable before each `load_clk` pulse (≥1).
- `clk` in 1: 100 MHz system clock. All logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse or level; begins a load when in IDLE.
- `abort` in 1: ends the load at the next byte boundary.
- `byte_in` in 8: program byte.
- `byte_valid` in 1: `byte_in` valid.
- `byte_last` in 1: qualifies `byte_in`; this is the final byte.
- `byte_ready` out 1: loader accepts `byte_in` this cycle.
- `hold_req` out 1: request to gate `bus_clk` low (drives HLT-style gating).
- `hold_ack` in 1: CPU clock confirmed stopped low. Synchronous to `clk`.
- `bus_out` out 8: value driven on the main bus.
- `bus_oe` out 1: tri-state enable for `bus_out`.
- `mi` out 1: memory-address-register-in strobe.
- `ri` out 1: RAM-in strobe.
- `load_clk` out 1: single-cycle clock pulse substituted for `bus_clk` while held.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on completion or abort.
- `count` out ADDR_W+1: bytes written in the current/last load.

## Operation
- Reset values: all outputs 0, `count` 0, state IDLE, address 0.
- FSM states: IDLE, HOLD, WAIT_BYTE, A_SETUP, A_CLK, D_SETUP, D_CLK, RELEASE.
- **IDLE:** `start`=1 → HOLD. The address register and `count` clear to 0 on this transition.
- **HOLD:** `hold_req`=1 from here through RELEASE exclusive. `hold_ack`=1 → WAIT_BYTE.
- **WAIT_BYTE:**
  - `byte_ready`=1.
  - On `byte_valid`: latch `byte_in` and `byte_last` → A_SETUP.
  - Else if `abort`: → RELEASE.
- **A_SETUP:** SETUP cycles. `bus_oe`=1, `bus_out`={zero-pad, addr}, `mi`=1.
- **A_CLK:** 1 cycle. Same drive, plus `load_clk`=1.
- **D_SETUP:** SETUP cycles. `bus_oe`=1, `bus_out`=latched byte, `ri`=1.
- **D_CLK:** 1 cycle. Same drive, plus `load_clk`=1.
  - On exit: addr += 1 (mod 2^ADDR_W) and `count` += 1.
  - Go to RELEASE if latched last, `abort`, or addr was 2^ADDR_W−1.
  - Otherwise go to WAIT_BYTE.
- **RELEASE:** 1 cycle. `hold_req`=0, `bus_oe`=0, `done`=1 → IDLE.
- `mi` and `ri` are never high in the same cycle. `bus_oe` is 0 outside the four drive states.
- `start` is ignored while `busy`. `abort` is ignored in IDLE. `abort` during A_*/D_* completes the current byte write first; a RAM word is never half-written.
- Deasserting `hold_ack` mid-load has no effect; the loader trusts the hold until RELEASE.
- Async reset at any point: outputs drop to 0 immediately, so the bus is released and the hold is dropped. RAM contents are whatever was already written.

## Timing
- `start` to `hold_req`: 1 cycle.
- `hold_ack` to `byte_ready`: 1 cycle.
- Per byte, from accept edge to `byte_ready` again: 2·(SETUP+1)+1 cycles. This is 7 at the default SETUP=2.
- `load_clk` rises only after the bus has been stable for SETUP cycles. Bus and strobe stay stable through the `load_clk` high cycle and change only on the following edge (hold time = 1 cycle).
- Last D_CLK to `done`: 1 cycle. `hold_req` falls in the same cycle `done` rises.
- Address wrap: the 2^ADDR_W-th byte ends the load. `count` reads 2^ADDR_W (hence the ADDR_W+1 width).

## Structure
- Shared package/header holds the FSM state encoding localparams and the bus width constant (8), reused by control_logic.
- Single module. A `setup_cnt` counter is inline; no sub-module is needed. The tri-state drive stays at top via the existing tri-state buffer, fed by `bus_out`/`bus_oe`.

## Test plan
- **Full load:** `start`, `hold_ack` after 3 cycles, stream 16 bytes 0x10..0x1F with `byte_last`=0 → 16 address writes 0..15, each with matching data. Exactly one `done` pulse; `count`=16; `hold_req` low after `done`.
- **Early last:** 3 bytes 0xAA, 0xBB, 0xCC with `byte_last` on the third → writes to addr 0,1,2; `count`=3; `done` 1 cycle after the third D_CLK.
- **Strobe timing:** SETUP=2 → `mi` high 3 cycles with `load_clk` on the 3rd, then `ri` high 3 cycles with `load_clk` on the 3rd. `mi`&`ri` never both high; `bus_out` constant while each strobe is high.
- **Abort mid-byte:** assert `abort` during D_SETUP of byte 5 → byte 5 completes, `count`=5, RELEASE, `done`. With `abort` in WAIT_BYTE at `count`=2 → no further writes, `done`.
- **Reset mid-operation:** `rst_n` low during A_CLK → same cycle `bus_oe`=`hold_req`=`load_clk`=`mi`=0. After release, a new `start` begins at addr 0.
- **Start while busy / hold stall:** `start` re-pulsed during a load → ignored, with no restart of the address sequence. `hold_ack` withheld 100 cycles → stays in HOLD, `bus_oe`=0, `byte_ready`=0.
